// File: rtl/video_stream_pattern_gen.sv
// AXI4-Stream video test-pattern source: frames of V_ACTIVE lines x H_ACTIVE beats with SOF on
// out_user and EOL on out_last, selectable ramp / colour bars / checkerboard / constant payload.
module video_stream_pattern_gen #(
  parameter int DATA_WIDTH = 40,
  parameter int H_ACTIVE   = 1920,
  parameter int V_ACTIVE   = 1080,
  parameter int LINE_GAP   = 0,
  parameter int FRAME_GAP  = 16,
  parameter int CHECK_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  input  logic [DATA_WIDTH-1:0] const_value,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_user,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic                  busy,
  output logic [15:0]           frame_cnt,
  output logic [1:0]            state_dbg
);

  // Handshake: a beat moves on any cycle with out_valid & out_ready. Once out_valid is raised,
  // out_data/out_user/out_last stay frozen and out_valid stays high until that transfer happens.

  localparam int          LANE_W  = DATA_WIDTH / 4;
  localparam logic [15:0] X_LAST  = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_LAST  = 16'(V_ACTIVE - 1);
  localparam logic [15:0] LG_LAST = 16'(LINE_GAP - 1);
  localparam logic [15:0] FG_LAST = 16'(FRAME_GAP - 1);
  localparam logic [15:0] BAR_W   = (H_ACTIVE / 8 > 0) ? 16'(H_ACTIVE / 8) : 16'd1;

  if (H_ACTIVE < 2 || V_ACTIVE < 1 || (DATA_WIDTH % 4) != 0) begin : g_param_check
    $error("video_stream_pattern_gen: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ACTIVE    = 2'd1,
    S_LINE_GAP  = 2'd2,
    S_FRAME_GAP = 2'd3
  } state_t;

  state_t                state, state_n;
  logic [15:0]           x, x_n, y, y_n, gap, gap_n, cnt_n, bar_full;
  logic [DATA_WIDTH-1:0] pix, pix_n, const_q, const_n, data_n, pat;
  logic [1:0]            sel_q, sel_n;
  logic [2:0]            bar;
  logic                  valid_n, user_n, last_n, done_n, load, drop, xfer;

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    pix_n   = pix;
    gap_n   = gap;
    sel_n   = sel_q;
    const_n = const_q;
    cnt_n   = frame_cnt;
    done_n  = 1'b0;
    load    = 1'b0;
    drop    = 1'b0;
    xfer    = out_valid & out_ready;
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_n = S_ACTIVE;
          sel_n   = pattern_sel;
          const_n = const_value;
          x_n     = '0;
          y_n     = '0;
          pix_n   = '0;
          load    = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (xfer) begin
          pix_n = pix + DATA_WIDTH'(1);
          if (x == X_LAST) begin
            x_n = '0;
            if (y == Y_LAST) begin
              y_n    = '0;
              pix_n  = '0;
              done_n = 1'b1;
              cnt_n  = frame_cnt + 16'd1;
              if (FRAME_GAP > 0) begin
                state_n = S_FRAME_GAP;
                gap_n   = '0;
                drop    = 1'b1;
              end else if (enable) begin
                sel_n   = pattern_sel;
                const_n = const_value;
                load    = 1'b1;
              end else begin
                state_n = S_IDLE;
                drop    = 1'b1;
              end
            end else begin
              y_n = y + 16'd1;
              if (LINE_GAP > 0) begin
                state_n = S_LINE_GAP;
                gap_n   = '0;
                drop    = 1'b1;
              end else begin
                load = 1'b1;
              end
            end
          end else begin
            x_n  = x + 16'd1;
            load = 1'b1;
          end
        end
      end
      S_LINE_GAP: begin
        gap_n = gap + 16'd1;
        if (gap == LG_LAST) begin
          state_n = S_ACTIVE;
          load    = 1'b1;
        end
      end
      S_FRAME_GAP: begin
        gap_n = gap + 16'd1;
        if (gap == FG_LAST) begin
          if (enable) begin
            state_n = S_ACTIVE;
            sel_n   = pattern_sel;
            const_n = const_value;
            load    = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Payload of the beat about to be presented, from its own coordinates.
    bar_full = x_n / BAR_W;
    bar      = (bar_full > 16'd7) ? 3'd7 : bar_full[2:0];
    pat      = '0;
    case (sel_n)
      2'd0: pat = pix_n;
      2'd1: begin
        for (int k = 0; k < 3; k++) pat[k*LANE_W +: LANE_W] = {LANE_W{bar[k]}};
      end
      2'd2: pat = {DATA_WIDTH{x_n[CHECK_LOG2] ^ y_n[CHECK_LOG2]}};
      default: pat = const_n;
    endcase

    valid_n = out_valid;
    user_n  = out_user;
    last_n  = out_last;
    data_n  = out_data;
    if (load) begin
      valid_n = 1'b1;
      user_n  = (x_n == 16'd0) && (y_n == 16'd0);
      last_n  = (x_n == X_LAST);
      data_n  = pat;
    end else if (drop) begin
      valid_n = 1'b0;
      user_n  = 1'b0;
      last_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      x          <= '0;
      y          <= '0;
      pix        <= '0;
      gap        <= '0;
      sel_q      <= '0;
      const_q    <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_user   <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_n;
      x          <= x_n;
      y          <= y_n;
      pix        <= pix_n;
      gap        <= gap_n;
      sel_q      <= sel_n;
      const_q    <= const_n;
      out_data   <= data_n;
      out_valid  <= valid_n;
      out_user   <= user_n;
      out_last   <= last_n;
      frame_done <= done_n;
      frame_cnt  <= cnt_n;
    end
  end

endmodule

// File: tb/tb_video_stream_pattern_gen.sv
// Directed bench for video_stream_pattern_gen: three instances (4x3 with gaps, 16x3 for bars,
// 4x3 with no frame gap for back-to-back frames and counter wrap).
module tb_video_stream_pattern_gen;
  localparam int DW = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, en_a, en_b, en_c, out_ready;
  logic [1:0]    pattern_sel;
  logic [DW-1:0] const_value;

  logic [DW-1:0] a_data, b_data, c_data;
  logic          a_valid, a_user, a_last, a_done, a_busy;
  logic          b_valid, b_user, b_last, b_done, b_busy;
  logic          c_valid, c_user, c_last, c_done, c_busy;
  logic [15:0]   a_cnt, b_cnt, c_cnt;
  logic [1:0]    a_state, b_state, c_state;

  video_stream_pattern_gen #(.DATA_WIDTH(DW), .H_ACTIVE(4), .V_ACTIVE(3), .LINE_GAP(2),
    .FRAME_GAP(3), .CHECK_LOG2(4)) dut_a (
    .clk(clk), .rstn(rstn), .enable(en_a), .pattern_sel(pattern_sel), .const_value(const_value),
    .out_data(a_data), .out_valid(a_valid), .out_user(a_user), .out_last(a_last),
    .out_ready(out_ready), .frame_done(a_done), .busy(a_busy), .frame_cnt(a_cnt),
    .state_dbg(a_state));

  video_stream_pattern_gen #(.DATA_WIDTH(DW), .H_ACTIVE(16), .V_ACTIVE(3), .LINE_GAP(2),
    .FRAME_GAP(3), .CHECK_LOG2(4)) dut_b (
    .clk(clk), .rstn(rstn), .enable(en_b), .pattern_sel(pattern_sel), .const_value(const_value),
    .out_data(b_data), .out_valid(b_valid), .out_user(b_user), .out_last(b_last),
    .out_ready(out_ready), .frame_done(b_done), .busy(b_busy), .frame_cnt(b_cnt),
    .state_dbg(b_state));

  video_stream_pattern_gen #(.DATA_WIDTH(DW), .H_ACTIVE(4), .V_ACTIVE(3), .LINE_GAP(2),
    .FRAME_GAP(0), .CHECK_LOG2(4)) dut_c (
    .clk(clk), .rstn(rstn), .enable(en_c), .pattern_sel(pattern_sel), .const_value(const_value),
    .out_data(c_data), .out_valid(c_valid), .out_user(c_user), .out_last(c_last),
    .out_ready(out_ready), .frame_done(c_done), .busy(c_busy), .frame_cnt(c_cnt),
    .state_dbg(c_state));

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_d[$];
  logic          got_u[$];
  logic          got_l[$];
  int            got_c[$];
  int            done_q[$];

  task automatic clear_logs();
    exp_q.delete(); got_d.delete(); got_u.delete(); got_l.delete(); got_c.delete();
    done_q.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0; en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; out_ready = 1'b0;
    pattern_sel = 2'd0; const_value = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", a_valid); end
    n_cmp++; if (a_user !== 1'b0) begin n_bad++; $display("FAIL reset_user: got %b want 0", a_user); end
    n_cmp++; if (a_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", a_last); end
    n_cmp++; if (a_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", a_data); end
    n_cmp++; if (a_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", a_done); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    n_cmp++; if (a_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", a_cnt); end
    n_cmp++; if (a_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", a_state); end
    rstn = 1'b1;
  endtask

  // Test 1: one ramp frame with full readiness; beat timing shows the line and frame gaps.
  task automatic test_ramp();
    int exp_cyc[12] = '{1, 2, 3, 4, 7, 8, 9, 10, 13, 14, 15, 16};
    clear_logs();
    pattern_sel = 2'd0; out_ready = 1'b1; en_a = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) en_a = 1'b0;
      if (a_valid && out_ready) begin
        got_d.push_back(a_data); got_u.push_back(a_user); got_l.push_back(a_last); got_c.push_back(k);
      end
      if (a_done) done_q.push_back(k);
    end
    for (int i = 0; i < 12; i++) exp_q.push_back(DW'(i));
    n_cmp++; if (got_d.size() != 12) begin n_bad++; $display("FAIL ramp_count: got %0d want 12", got_d.size()); end
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (i >= got_d.size()) begin
        n_bad++; $display("FAIL ramp_beat%0d: got none want d=%h", i, exp_q[i]);
      end else if (got_d[i] !== exp_q[i] || got_u[i] !== (i == 0) || got_l[i] !== (i % 4 == 3)
                   || got_c[i] != exp_cyc[i]) begin
        n_bad++;
        $display("FAIL ramp_beat%0d: got d=%h u=%b l=%b cyc=%0d want d=%h u=%b l=%b cyc=%0d", i,
                 got_d[i], got_u[i], got_l[i], got_c[i], exp_q[i], (i == 0), (i % 4 == 3), exp_cyc[i]);
      end
    end
    n_cmp++; if (done_q.size() != 1) begin n_bad++; $display("FAIL ramp_done_pulses: got %0d want 1", done_q.size()); end
    if (done_q.size() > 0) begin
      n_cmp++; if (done_q[0] != 17) begin n_bad++; $display("FAIL ramp_done_cycle: got %0d want 17", done_q[0]); end
    end
    n_cmp++; if (a_cnt !== 16'd1) begin n_bad++; $display("FAIL ramp_frame_cnt: got %0d want 1", a_cnt); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL ramp_idle: got busy=%b want 0", a_busy); end
  endtask

  // Test 2: random backpressure; same beat sequence, outputs frozen while stalled.
  task automatic test_backpressure();
    logic          prev_stall, pu, pl;
    logic [DW-1:0] pd;
    bit            fin;
    int            k;
    clear_logs();
    prev_stall = 1'b0; pu = 1'b0; pl = 1'b0; pd = '0; fin = 1'b0; k = 0;
    pattern_sel = 2'd0; en_a = 1'b1; out_ready = 1'($urandom_range(0, 1));
    while (!fin && k < 400) begin
      @(negedge clk);
      k++;
      if (k == 1) en_a = 1'b0;
      if (prev_stall) begin
        n_cmp++;
        if (a_valid !== 1'b1 || a_data !== pd || a_user !== pu || a_last !== pl) begin
          n_bad++;
          $display("FAIL bp_hold@%0d: got v=%b d=%h u=%b l=%b want v=1 d=%h u=%b l=%b", k,
                   a_valid, a_data, a_user, a_last, pd, pu, pl);
        end
      end
      if (got_d.size() == 12 && !a_busy) fin = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      if (a_valid && out_ready) begin
        got_d.push_back(a_data); got_u.push_back(a_user); got_l.push_back(a_last);
      end
      prev_stall = a_valid && !out_ready;
      pd = a_data; pu = a_user; pl = a_last;
    end
    out_ready = 1'b1;
    n_cmp++; if (!fin) begin n_bad++; $display("FAIL bp_timeout: got %0d beats want 12 then idle", got_d.size()); end
    for (int i = 0; i < 12; i++) exp_q.push_back(DW'(i));
    n_cmp++; if (got_d.size() != 12) begin n_bad++; $display("FAIL bp_count: got %0d want 12", got_d.size()); end
    for (int i = 0; i < 12 && i < got_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_q[i] || got_u[i] !== (i == 0) || got_l[i] !== (i % 4 == 3)) begin
        n_bad++;
        $display("FAIL bp_beat%0d: got d=%h u=%b l=%b want d=%h u=%b l=%b", i,
                 got_d[i], got_u[i], got_l[i], exp_q[i], (i == 0), (i % 4 == 3));
      end
    end
    n_cmp++; if (a_cnt !== 16'd2) begin n_bad++; $display("FAIL bp_frame_cnt: got %0d want 2", a_cnt); end
  endtask

  // Test 3: enable dropped on beat 5; frame runs to completion, frame gap, then idle.
  task automatic test_enable_drop();
    int gap;
    clear_logs();
    gap = 0;
    pattern_sel = 2'd0; out_ready = 1'b1; en_a = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (got_d.size() == 12 && !a_valid && a_busy) gap++;
      if (a_valid) begin
        got_d.push_back(a_data); got_l.push_back(a_last);
        if (got_d.size() == 6) en_a = 1'b0;
      end
    end
    n_cmp++; if (got_d.size() != 12) begin n_bad++; $display("FAIL drop_count: got %0d want 12", got_d.size()); end
    if (got_d.size() == 12) begin
      n_cmp++;
      if (got_d[11] !== DW'(11) || got_l[11] !== 1'b1) begin
        n_bad++; $display("FAIL drop_last_beat: got d=%h l=%b want d=%h l=1", got_d[11], got_l[11], DW'(11));
      end
    end
    n_cmp++; if (gap != 3) begin n_bad++; $display("FAIL drop_gap: got %0d want 3", gap); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL drop_busy: got %b want 0", a_busy); end
    n_cmp++; if (a_state !== 2'd0) begin n_bad++; $display("FAIL drop_state: got %0d want 0", a_state); end
    n_cmp++; if (a_cnt !== 16'd3) begin n_bad++; $display("FAIL drop_frame_cnt: got %0d want 3", a_cnt); end
  endtask

  // Test 4: colour bars on a 16-beat line; pattern switch lands only at the next SOF.
  task automatic test_bars();
    int            bi[11] = '{0, 1, 2, 3, 4, 8, 14, 15, 31, 47, 48};
    logic [DW-1:0] bv[11];
    logic [DW-1:0] cv;
    bit            fin;
    int            k;
    cv = 40'h12_3456_789A;
    bv = '{40'h0, 40'h0, 40'h3FF, 40'h3FF, 40'hFFC00, 40'h3FF00000, 40'h3FFFFFFF,
           40'h3FFFFFFF, 40'h3FFFFFFF, 40'h3FFFFFFF, cv};
    clear_logs();
    fin = 1'b0; k = 0;
    pattern_sel = 2'd1; const_value = '0; out_ready = 1'b1; en_b = 1'b1;
    while (!fin && k < 300) begin
      @(negedge clk);
      k++;
      if (b_valid) begin
        got_d.push_back(b_data); got_u.push_back(b_user);
        if (got_d.size() == 20) begin pattern_sel = 2'd3; const_value = cv; end
        if (got_d.size() == 49) en_b = 1'b0;
      end
      if (got_d.size() >= 49 && !b_busy) fin = 1'b1;
    end
    n_cmp++; if (got_d.size() != 96) begin n_bad++; $display("FAIL bars_count: got %0d want 96", got_d.size()); end
    for (int i = 0; i < 11; i++) begin
      n_cmp++;
      if (bi[i] >= got_d.size()) begin
        n_bad++; $display("FAIL bars_beat%0d: got none want %h", bi[i], bv[i]);
      end else if (got_d[bi[i]] !== bv[i]) begin
        n_bad++; $display("FAIL bars_beat%0d: got %h want %h", bi[i], got_d[bi[i]], bv[i]);
      end
    end
    if (got_d.size() == 96) begin
      n_cmp++; if (got_u[48] !== 1'b1) begin n_bad++; $display("FAIL bars_sof2: got user=%b want 1", got_u[48]); end
      n_cmp++; if (got_d[95] !== cv) begin n_bad++; $display("FAIL bars_const_end: got %h want %h", got_d[95], cv); end
    end
    pattern_sel = 2'd0; const_value = '0;
  endtask

  // Test 5: reset pulse mid-frame truncates the stream; next frame restarts at SOF.
  task automatic test_mid_reset();
    int k;
    clear_logs();
    k = 0;
    pattern_sel = 2'd0; out_ready = 1'b1; en_a = 1'b1;
    while (got_d.size() < 7 && k < 30) begin
      @(negedge clk);
      k++;
      if (a_valid) got_d.push_back(a_data);
    end
    n_cmp++; if (got_d.size() != 7) begin n_bad++; $display("FAIL rst_reach_beat6: got %0d beats want 7", got_d.size()); end
    if (got_d.size() == 7) begin
      n_cmp++; if (got_d[6] !== DW'(6)) begin n_bad++; $display("FAIL rst_beat6: got %h want %h", got_d[6], DW'(6)); end
    end
    rstn = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", a_valid); end
    n_cmp++; if (a_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_frame_cnt: got %0d want 0", a_cnt); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", a_busy); end
    rstn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (a_valid !== 1'b1 || a_user !== 1'b1 || a_data !== '0) begin
      n_bad++; $display("FAIL rst_restart: got v=%b u=%b d=%h want v=1 u=1 d=0", a_valid, a_user, a_data);
    end
    en_a = 1'b0;
    k = 0;
    while (a_busy && k < 60) begin @(negedge clk); k++; end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL rst_finish: got busy=%b want 0", a_busy); end
    n_cmp++; if (a_cnt !== 16'd1) begin n_bad++; $display("FAIL rst_cnt_after: got %0d want 1", a_cnt); end
  endtask

  // Test 6: no frame gap; next SOF directly follows the previous EOL, counter wraps.
  task automatic test_back_to_back();
    logic [15:0] cnt_at_done[$];
    clear_logs();
    force dut_c.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut_c.frame_cnt;
    pattern_sel = 2'd0; out_ready = 1'b1; en_c = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (c_valid) begin
        got_d.push_back(c_data); got_u.push_back(c_user); got_l.push_back(c_last); got_c.push_back(k);
        if (got_d.size() == 13) en_c = 1'b0;
      end
      if (c_done) begin done_q.push_back(k); cnt_at_done.push_back(c_cnt); end
    end
    n_cmp++; if (got_d.size() != 24) begin n_bad++; $display("FAIL b2b_count: got %0d want 24", got_d.size()); end
    if (got_d.size() >= 13) begin
      n_cmp++; if (got_l[11] !== 1'b1 || got_c[11] != 16) begin
        n_bad++; $display("FAIL b2b_eof: got l=%b cyc=%0d want l=1 cyc=16", got_l[11], got_c[11]);
      end
      n_cmp++; if (got_u[12] !== 1'b1 || got_d[12] !== '0 || got_c[12] != 17) begin
        n_bad++; $display("FAIL b2b_sof: got u=%b d=%h cyc=%0d want u=1 d=0 cyc=17", got_u[12], got_d[12], got_c[12]);
      end
    end
    n_cmp++; if (done_q.size() != 2) begin n_bad++; $display("FAIL b2b_done_pulses: got %0d want 2", done_q.size()); end
    if (done_q.size() > 0) begin
      n_cmp++; if (done_q[0] != 17 || cnt_at_done[0] !== 16'd0) begin
        n_bad++; $display("FAIL b2b_wrap: got cyc=%0d cnt=%h want cyc=17 cnt=0000", done_q[0], cnt_at_done[0]);
      end
    end
    n_cmp++; if (c_cnt !== 16'd1) begin n_bad++; $display("FAIL b2b_frame_cnt: got %0d want 1", c_cnt); end
    n_cmp++; if (c_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got busy=%b want 0", c_busy); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_backpressure();
    test_enable_drop();
    test_bars();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
